// File: rtl/ps2_pkg.sv
// ps2_pkg: receive FSM states, scancode constants and key bit indices for the PS/2 key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;

  // One-hot key mask for a code; the E0 prefix selects the arrow set instead of WASD.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    key_mask = '0;
    key_mask[KEY_UP]    = code == (ext ? SC_UP    : SC_W);
    key_mask[KEY_LEFT]  = code == (ext ? SC_LEFT  : SC_A);
    key_mask[KEY_DOWN]  = code == (ext ? SC_DOWN  : SC_S);
    key_mask[KEY_RIGHT] = code == (ext ? SC_RIGHT : SC_D);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes the raw PS/2 lines into clk and flags falling edges of ps2_clk.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] clk_q, dat_q;
  logic                   prev_q;

  // Flops reset to 1 so an idle bus never produces a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q  <= '1;
      dat_q  <= '1;
      prev_q <= 1'b1;
    end else begin
      clk_q[0] <= ps2_clk_i;
      dat_q[0] <= ps2_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_q[i] <= clk_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      prev_q <= clk_q[SYNC_STAGES-1];
    end
  end

  assign data_o = dat_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~clk_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver and WASD/arrow held-key decoder.
// Define PS2_PARITY_CHECK_EN to discard frames with bad odd parity.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          data, fall, done, err;
  ps2_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    key_q, key_d, mask;
  logic [7:0]    sc_q, sc_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          valid_q, err_q;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .data_o    (data),
    .fall_o    (fall)
  );

  assign mask = key_mask(shift_q, ext_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    to_d     = '0;
    done     = 1'b0;
    err      = 1'b0;
    if (state_q != IDLE) to_d = fall ? '0 : to_q + 1'b1;
    if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = data ? IDLE : DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shift_d = {data, shift_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_ok_d = ^{shift_q, data};
`else
          par_ok_d = 1'b1;
`endif
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          done    = data & par_ok_q;
          err     = ~(data & par_ok_q);
        end
      endcase
    end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      cnt_d   = '0;
      to_d    = '0;
      err     = 1'b1;
    end
  end

  // Prefix bytes only arm the flags; any other byte consumes and clears them.
  always_comb begin
    key_d = key_q;
    sc_d  = sc_q;
    ext_d = ext_q;
    brk_d = brk_q;
    if (done) begin
      sc_d  = shift_q;
      ext_d = (shift_q == SC_EXT) | (ext_q & shift_q == SC_BRK);
      brk_d = (shift_q == SC_BRK) | (brk_q & shift_q == SC_EXT);
      if (shift_q != SC_EXT && shift_q != SC_BRK) key_d = brk_q ? key_q & ~mask : key_q | mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b1;
      to_q     <= '0;
      key_q    <= '0;
      sc_q     <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      to_q     <= to_d;
      key_q    <= key_d;
      sc_q     <= sc_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      valid_q  <= done;
      err_q    <= err;
    end
  end

  assign key            = key_q;
  assign scancode       = sc_q;
  assign scancode_valid = valid_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed frame sequences against ps2_key_decoder with hand-derived expectations.
// Honours PS2_PARITY_CHECK_EN for the corrupted-parity frame.
module tb_ps2_key_decoder;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] scancode;
  logic       scancode_valid, frame_err;
  int         nv = 0, ne = 0, pass = 0, total = 0;
  int         v0, e0, lat;
  logic [7:0] b;

  ps2_key_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .key           (key),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (scancode_valid) nv++;
    if (frame_err) ne++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Frame bits: start 0, data LSB first, odd parity (optionally flipped), stop 1.
  task automatic send(input logic [7:0] d, input bit flip, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d);
    send(d, 1'b0, 11);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_key", key, 4'h0);
    chk("rst_scancode", scancode, 8'h00);
    chk("rst_valid", scancode_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    v0 = nv; e0 = ne;
    frame(8'h1D);
    chk("w_pulses", nv - v0, 1);
    chk("w_scancode", scancode, 8'h1D);
    chk("w_key", key, 4'b0001);

    v0 = nv;
    frame(8'hF0); frame(8'h1D);
    chk("w_rel_pulses", nv - v0, 2);
    chk("w_rel_key", key, 4'b0000);
    chk("w_rel_err", ne - e0, 0);

    frame(8'hE0); frame(8'h74); frame(8'hE0); frame(8'h6B);
    chk("arrows_key", key, 4'b1010);
    frame(8'hE0); frame(8'hF0); frame(8'h74);
    chk("right_rel_key", key, 4'b0010);
    frame(8'hE0); frame(8'hF0); frame(8'h6B);
    chk("left_rel_key", key, 4'b0000);

    v0 = nv; e0 = ne;
    send(8'h1C, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", ne - e0, 1);
    chk("par_valid", nv - v0, 0);
    chk("par_key", key, 4'b0000);
`else
    chk("par_err", ne - e0, 0);
    chk("par_valid", nv - v0, 1);
    chk("par_key", key, 4'b0010);
`endif
    frame(8'hF0); frame(8'h1C);
    chk("a_rel_key", key, 4'b0000);

    frame(8'hE0); frame(8'h55); frame(8'h75);
    chk("ext_clear_key", key, 4'b0000);
    chk("ext_clear_scancode", scancode, 8'h75);

    v0 = nv; e0 = ne;
    send(8'h23, 1'b0, 5);
    lat = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      lat++;
      if (ne != e0) break;
    end
    chk("to_err", ne - e0, 1);
    chk("to_latency", (lat >= 64960 && lat <= 65010), 1'b1);
    chk("to_valid", nv - v0, 0);
    repeat (10) @(negedge clk);
    frame(8'h23);
    chk("to_next_key", key, 4'b1000);

    frame(8'h1D); frame(8'h1C); frame(8'h1B);
    chk("all_key", key, 4'b1111);
    frame(8'h23);
    chk("repeat_key", key, 4'b1111);
    frame(8'h55);
    chk("unmapped_key", key, 4'b1111);
    chk("unmapped_scancode", scancode, 8'h55);

    v0 = nv; e0 = ne;
    b = 8'h1B;
    send(b, 1'b0, 6);
    ps2_data = b[5];
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_key", key, 4'h0);
    chk("midrst_scancode", scancode, 8'h00);
    chk("midrst_valid", scancode_valid, 1'b0);
    chk("midrst_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_pulses", (nv - v0) + (ne - e0), 0);
    frame(8'h1B);
    chk("post_rst_key", key, 4'b0100);
    chk("post_rst_pulses", nv - v0, 1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
